// File: rtl/scope_bus_ctrl_if.sv
// scope_bus_ctrl_if: host request/response channel plus shared scope command bus.
interface scope_bus_ctrl_if #(
  parameter int NUM_TAPS = 4,
  parameter int BUSW     = 64,
  parameter int LENW     = 16
);
  localparam int TAPW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_rw;
  logic                     req_bcast;
  logic [TAPW-1:0]          req_tap;
  logic [LENW-1:0]          req_len;
  logic [BUSW-1:0]          req_data;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [BUSW-1:0]          rsp_data;
  logic                     rsp_err;
  logic                     rsp_last;
  logic [BUSW-1:0]          tap_bus_in;
  logic [NUM_TAPS-1:0]      tap_bus_write;
  logic [NUM_TAPS-1:0]      tap_bus_read;
  logic [NUM_TAPS*BUSW-1:0] tap_bus_out;
  modport slave (
    input  req_valid, req_rw, req_bcast, req_tap, req_len, req_data, rsp_ready, tap_bus_out,
    output req_ready, rsp_valid, rsp_data, rsp_err, rsp_last, tap_bus_in, tap_bus_write, tap_bus_read
  );
  modport master (
    output req_valid, req_rw, req_bcast, req_tap, req_len, req_data, rsp_ready, tap_bus_out,
    input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_last, tap_bus_in, tap_bus_write, tap_bus_read
  );
endinterface

// File: rtl/scope_bus_ctrl.sv
// scope_bus_ctrl: sequences host requests into one-cycle scope strobes, expanding burst reads.
module scope_bus_ctrl #(
  parameter int NUM_TAPS = 4,
  parameter int BUSW     = 64,
  parameter int LENW     = 16
) (
  input  logic              clk,
  input  logic              reset,
  scope_bus_ctrl_if.slave   bus
);
  localparam int TAPW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
  state_t              r_state, w_next;
  logic                r_rw, r_bcast;
  logic [TAPW-1:0]     r_tap;
  logic [LENW-1:0]     r_cnt;
  logic [BUSW-1:0]     r_bus_in, r_rsp_data;
  logic                r_rsp_err, r_rsp_last;
  logic                w_accept, w_err;
  logic [NUM_TAPS-1:0] w_onehot;
  logic [BUSW-1:0]     w_tap_data;
  assign w_accept   = r_state == IDLE && bus.req_valid;
  assign w_err      = bus.req_bcast ? !bus.req_rw : 32'(bus.req_tap) >= NUM_TAPS;
  assign w_onehot   = NUM_TAPS'(1) << r_tap;
  assign w_tap_data = bus.tap_bus_out[32'(r_tap)*BUSW +: BUSW];
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  // A pending response blocks further reads: each scope read is destructive.
  always_comb
    w_next = r_state == IDLE  ? (!bus.req_valid ? IDLE : w_err ? RESP : bus.req_rw ? WRITE : READ) :
             r_state == RESP  ? (!bus.rsp_ready ? RESP : r_rsp_last ? IDLE : READ) :
             RESP;
  always_ff @(posedge clk)
    if (reset) begin
      r_rw       <= 1'b0;
      r_bcast    <= 1'b0;
      r_tap      <= '0;
      r_cnt      <= '0;
      r_bus_in   <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_rsp_last <= 1'b0;
    end else if (w_accept) begin
      r_rw       <= bus.req_rw;
      r_bcast    <= bus.req_bcast;
      r_tap      <= bus.req_tap;
      r_cnt      <= bus.req_len == '0 ? LENW'(1) : bus.req_len;
      r_bus_in   <= bus.req_data;
      r_rsp_data <= '0;
      r_rsp_err  <= w_err;
      r_rsp_last <= w_err || bus.req_rw;
    end else if (r_state == READ) begin
      r_cnt      <= r_cnt - LENW'(1);
      r_rsp_data <= w_tap_data;
      r_rsp_err  <= 1'b0;
      r_rsp_last <= r_cnt == LENW'(1);
    end
  always_comb begin
    bus.req_ready     = !reset && r_state == IDLE;
    bus.rsp_valid     = !reset && r_state == RESP;
    bus.rsp_data      = r_rsp_data;
    bus.rsp_err       = r_rsp_err;
    bus.rsp_last      = r_rsp_last;
    bus.tap_bus_in    = r_bus_in;
    bus.tap_bus_write = (!reset && r_state == WRITE) ? (r_bcast ? '1 : w_onehot) : '0;
    bus.tap_bus_read  = (!reset && r_state == READ) ? w_onehot : '0;
  end
endmodule

// File: tb/tb_scope_bus_ctrl.sv
// tb_scope_bus_ctrl: directed checks of scope_bus_ctrl against destructive-read scope models.
module tb_scope_bus_ctrl;
  localparam int NT = 5;
  localparam int BW = 64;
  localparam int LW = 4;
  localparam int TW = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [BW-1:0] base [NT];
  int ptr  [NT] = '{default: 0};
  int rd_n [NT] = '{default: 0};
  int wr_n [NT] = '{default: 0};
  int rd_tot = 0;
  int wr_tot = 0;
  scope_bus_ctrl_if #(.NUM_TAPS(NT), .BUSW(BW), .LENW(LW)) bus ();
  scope_bus_ctrl #(.NUM_TAPS(NT), .BUSW(BW), .LENW(LW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always_comb
    for (int i = 0; i < NT; i++) bus.tap_bus_out[i*BW +: BW] = base[i] + BW'(ptr[i]);
  always @(posedge clk) begin
    if (bus.tap_bus_read != '0) rd_tot <= rd_tot + 1;
    if (bus.tap_bus_write != '0) wr_tot <= wr_tot + 1;
    for (int i = 0; i < NT; i++) begin
      if (bus.tap_bus_read[i]) begin
        ptr[i]  <= ptr[i] + 1;
        rd_n[i] <= rd_n[i] + 1;
      end
      if (bus.tap_bus_write[i]) wr_n[i] <= wr_n[i] + 1;
    end
  end
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic rw, input logic bc, input logic [TW-1:0] tap,
                     input logic [LW-1:0] len, input logic [BW-1:0] d);
    bus.req_rw = rw;
    bus.req_bcast = bc;
    bus.req_tap = tap;
    bus.req_len = len;
    bus.req_data = d;
    bus.req_valid = 1'b1;
    cycle();
    bus.req_valid = 1'b0;
  endtask
  task automatic test_reset();
    repeat (3) cycle();
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_last} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b expected 0000", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_last});
    end
    checks++;
    if ({bus.rsp_data, bus.tap_bus_in, bus.tap_bus_write, bus.tap_bus_read} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%b/%b expected zeros", bus.rsp_data, bus.tap_bus_in, bus.tap_bus_write, bus.tap_bus_read);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b expected 1", bus.req_ready);
    end
  endtask
  task automatic test_write();
    int w0 = wr_n[2];
    req(1'b1, 1'b0, 3'd2, 4'd0, 64'h4);
    checks++;
    if (bus.tap_bus_write !== 5'b00100 || bus.tap_bus_in !== 64'h4 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_strobe got wr=%b in=%h rdy=%b expected 00100/4/0", bus.tap_bus_write, bus.tap_bus_in, bus.req_ready);
    end
    cycle();
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_last} !== 3'b101 || bus.rsp_data !== '0 || bus.tap_bus_write !== '0) begin
      errors++;
      $display("FAIL wr_ack got v/e/l=%b data=%h wr=%b expected 101/0/0", {bus.rsp_valid, bus.rsp_err, bus.rsp_last}, bus.rsp_data, bus.tap_bus_write);
    end
    checks++;
    if (wr_n[2] - w0 !== 1) begin
      errors++;
      $display("FAIL wr_count got %0d expected 1", wr_n[2] - w0);
    end
    bus.rsp_ready = 1'b1;
    cycle();
    bus.rsp_ready = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL wr_idle got v/rdy=%b expected 01", {bus.rsp_valid, bus.req_ready});
    end
  endtask
  task automatic test_bcast();
    int w0 = wr_tot;
    int acks = 0;
    req(1'b1, 1'b1, 3'd0, 4'd0, 64'h5);
    checks++;
    if (bus.tap_bus_write !== 5'b11111 || bus.tap_bus_in !== 64'h5) begin
      errors++;
      $display("FAIL bc_strobe got wr=%b in=%h expected 11111/5", bus.tap_bus_write, bus.tap_bus_in);
    end
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.rsp_valid) acks++;
      cycle();
    end
    bus.rsp_ready = 1'b0;
    checks++;
    if (acks !== 1 || wr_tot - w0 !== 1) begin
      errors++;
      $display("FAIL bc_acks got acks=%0d strobes=%0d expected 1/1", acks, wr_tot - w0);
    end
  endtask
  task automatic test_read();
    base[1] = 64'hABCD;
    req(1'b0, 1'b0, 3'd1, 4'd1, 64'h33);
    checks++;
    if (bus.tap_bus_read !== 5'b00010 || bus.tap_bus_write !== '0) begin
      errors++;
      $display("FAIL rd_strobe got rd=%b wr=%b expected 00010/00000", bus.tap_bus_read, bus.tap_bus_write);
    end
    cycle();
    checks++;
    if (bus.rsp_data !== 64'hABCD || {bus.rsp_valid, bus.rsp_err, bus.rsp_last} !== 3'b101 || bus.tap_bus_read !== '0) begin
      errors++;
      $display("FAIL rd_rsp got data=%h v/e/l=%b rd=%b expected abcd/101/0", bus.rsp_data, {bus.rsp_valid, bus.rsp_err, bus.rsp_last}, bus.tap_bus_read);
    end
    bus.rsp_ready = 1'b1;
    cycle();
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.tap_bus_in !== 64'h33 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_done got in=%h rdy=%b expected 33/1", bus.tap_bus_in, bus.req_ready);
    end
  endtask
  task automatic test_burst();
    int r0 = rd_n[0];
    int s, n;
    base[0] = 64'd10;
    req(1'b0, 1'b0, 3'd0, 4'd3, 64'h77);
    for (int b = 0; b < 3; b++) begin
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 10) begin
        cycle();
        n++;
      end
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 64'(10 + b) || bus.rsp_last !== (b == 2)) begin
        errors++;
        $display("FAIL burst_beat%0d got v=%b data=%0d last=%b expected 1/%0d/%b", b, bus.rsp_valid, bus.rsp_data, bus.rsp_last, 10 + b, b == 2);
      end
      if (b == 1) begin
        s = rd_tot;
        repeat (5) cycle();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 64'd11 || rd_tot !== s) begin
          errors++;
          $display("FAIL burst_stall got v=%b data=%0d strobes=%0d expected 1/11/0", bus.rsp_valid, bus.rsp_data, rd_tot - s);
        end
      end
      bus.rsp_ready = 1'b1;
      cycle();
      bus.rsp_ready = 1'b0;
    end
    checks++;
    if (rd_n[0] - r0 !== 3 || bus.tap_bus_in !== 64'h77 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL burst_end got strobes=%0d in=%h rdy=%b expected 3/77/1", rd_n[0] - r0, bus.tap_bus_in, bus.req_ready);
    end
  endtask
  task automatic test_errors();
    logic [4:0] vec [3] = '{{1'b0, 1'b0, 3'd5}, {1'b0, 1'b1, 3'd1}, {1'b1, 1'b0, 3'd7}};
    int r0 = rd_tot;
    int w0 = wr_tot;
    for (int k = 0; k < 3; k++) begin
      req(vec[k][4], vec[k][3], vec[k][2:0], 4'd2, 64'hFF);
      checks++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_last} !== 3'b111 || bus.rsp_data !== '0 || bus.tap_bus_read !== '0 || bus.tap_bus_write !== '0) begin
        errors++;
        $display("FAIL err%0d got v/e/l=%b data=%h rd=%b wr=%b expected 111/0/0/0", k, {bus.rsp_valid, bus.rsp_err, bus.rsp_last}, bus.rsp_data, bus.tap_bus_read, bus.tap_bus_write);
      end
      bus.rsp_ready = 1'b1;
      cycle();
      bus.rsp_ready = 1'b0;
      checks++;
      if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
        errors++;
        $display("FAIL err%0d_idle got v/rdy=%b expected 01", k, {bus.rsp_valid, bus.req_ready});
      end
    end
    checks++;
    if (rd_tot !== r0 || wr_tot !== w0) begin
      errors++;
      $display("FAIL err_strobes got rd=%0d wr=%0d expected 0/0", rd_tot - r0, wr_tot - w0);
    end
  endtask
  task automatic test_len_edges();
    logic [LW-1:0] lens [2] = '{4'd15, 4'd0};
    int beats [2] = '{15, 1};
    int r0, n, lasts;
    base[3] = '0;
    for (int k = 0; k < 2; k++) begin
      r0 = rd_n[3];
      lasts = 0;
      bus.rsp_ready = 1'b1;
      req(1'b0, 1'b0, 3'd3, lens[k], 64'h0);
      n = 1;
      while (bus.req_ready !== 1'b1 && n < 60) begin
        if (bus.rsp_valid && bus.rsp_last) lasts++;
        cycle();
        n++;
      end
      bus.rsp_ready = 1'b0;
      checks++;
      if (n !== 2 * beats[k] + 1 || rd_n[3] - r0 !== beats[k] || lasts !== 1) begin
        errors++;
        $display("FAIL len%0d got cycles=%0d beats=%0d lasts=%0d expected %0d/%0d/1", lens[k], n, rd_n[3] - r0, lasts, 2 * beats[k] + 1, beats[k]);
      end
    end
  endtask
  task automatic test_reset_mid();
    int r0 = rd_n[2];
    base[2] = 64'd100 - 64'(ptr[2]);
    bus.rsp_ready = 1'b1;
    req(1'b0, 1'b0, 3'd2, 4'd4, 64'h0);
    cycle();
    cycle();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.tap_bus_read !== '0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got rd=%b v=%b rdy=%b expected 0/0/0", bus.tap_bus_read, bus.rsp_valid, bus.req_ready);
    end
    cycle();
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL rst_after got rdy/v=%b expected 10", {bus.req_ready, bus.rsp_valid});
    end
    repeat (4) cycle();
    checks++;
    if (rd_n[2] - r0 !== 1) begin
      errors++;
      $display("FAIL rst_strobes got %0d expected 1", rd_n[2] - r0);
    end
    bus.rsp_ready = 1'b0;
    req(1'b0, 1'b0, 3'd2, 4'd1, 64'h0);
    cycle();
    checks++;
    if (bus.rsp_data !== 64'd101 || {bus.rsp_valid, bus.rsp_err, bus.rsp_last} !== 3'b101) begin
      errors++;
      $display("FAIL rst_fresh got data=%0d v/e/l=%b expected 101/101", bus.rsp_data, {bus.rsp_valid, bus.rsp_err, bus.rsp_last});
    end
    bus.rsp_ready = 1'b1;
    cycle();
    bus.rsp_ready = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < NT; i++) base[i] = 64'(i) << 32;
    bus.req_valid = 1'b0;
    bus.req_rw = 1'b0;
    bus.req_bcast = 1'b0;
    bus.req_tap = '0;
    bus.req_len = '0;
    bus.req_data = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_write();
    test_bcast();
    test_read();
    test_burst();
    test_errors();
    test_len_edges();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
